// File: rtl/bsg_hash_bank_dispatch.sv
// ---------------------------------------------------------------------------
// bsg_hash_bank_dispatch
//
// Purpose:
//    Sits downstream of an address-to-bank hash. Each incoming address is split
//    into a bank select (low lg_banks_lp bits) and a bank-local index (the
//    remaining high bits). The index is queued in that bank's FIFO. Each bank
//    drains its own FIFO with a valid/yumi handshake, so a stalled bank only
//    blocks requests that target it.
//
// Parameters:
//    banks_p  number of banks (power of two, >= 1)
//    width_p  input address width
//    els_p    per-bank FIFO depth (power of two, >= 2)
//
// Ports:
//    clk_i        clock, all state updates on the rising edge
//    reset_i      asynchronous active-high reset; empties every FIFO at once
//    v_i          input address valid
//    addr_i       input address
//    ready_o      target bank FIFO (selected by addr_i) is not full
//    v_o          per-bank FIFO head valid
//    index_o      per-bank head index, bank b in slice b
//    yumi_i       per-bank consume of the head entry
//    stall_cnt_o  (only with BSG_HASH_BANK_DISPATCH_PERF_EN) saturating count
//                 of cycles with v_i & ~ready_o
//
// Configuration macro:
//    BSG_HASH_BANK_DISPATCH_PERF_EN  adds the stall_cnt_o performance counter.
// ---------------------------------------------------------------------------
module bsg_hash_bank_dispatch #(
   parameter int banks_p = 2,
   parameter int width_p = 32,
   parameter int els_p   = 4,
   localparam int lg_banks_lp    = (banks_p == 1) ? 0 : $clog2(banks_p),
   localparam int index_width_lp = width_p - lg_banks_lp
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                v_i,
   input  logic [width_p-1:0]                  addr_i,
   output logic                                ready_o,
   output logic [banks_p-1:0]                  v_o,
   output logic [banks_p*index_width_lp-1:0]   index_o,
   input  logic [banks_p-1:0]                  yumi_i
`ifdef BSG_HASH_BANK_DISPATCH_PERF_EN
  ,output logic [31:0]                         stall_cnt_o
`endif
);

   // A single bank still needs a 1-bit select so the vectors stay legal.
   localparam int sel_width_lp = (lg_banks_lp == 0) ? 1 : lg_banks_lp;
   localparam int lg_els_lp    = $clog2(els_p);
   localparam int cnt_width_lp = lg_els_lp + 1;

   logic [sel_width_lp-1:0]   bank_sel;
   logic [index_width_lp-1:0] addr_index;
   logic [banks_p-1:0]        full;
   logic                      enq_ok;

   generate
      if (banks_p == 1) begin : g_single_bank
         assign bank_sel = '0;
      end else begin : g_multi_bank
         assign bank_sel = addr_i[lg_banks_lp-1:0];
      end
   endgenerate

   assign addr_index = addr_i[width_p-1:lg_banks_lp];

   // Readiness depends only on the addressed bank, never on v_i, so upstream
   // can look at ready_o before deciding to present the request.
   assign ready_o = ~full[bank_sel];
   assign enq_ok  = v_i & ready_o;

   genvar gi;
   generate
      for (gi = 0; gi < banks_p; gi++) begin : g_bank
         logic [cnt_width_lp-1:0]   count_reg;
         logic [cnt_width_lp-1:0]   count_next;
         logic [lg_els_lp-1:0]      rd_ptr_reg;
         logic [lg_els_lp-1:0]      wr_ptr_reg;
         logic [index_width_lp-1:0] mem_reg [els_p];
         logic                      enq;
         logic                      deq;

         assign enq = enq_ok & (bank_sel == sel_width_lp'(gi));
         assign deq = yumi_i[gi];

         // full is taken from the registered count only, so a yumi in the
         // same cycle does not open a slot until the next cycle.
         assign full[gi] = (count_reg == cnt_width_lp'(els_p));
         assign v_o[gi]  = (count_reg != '0);
         assign index_o[gi*index_width_lp +: index_width_lp] = mem_reg[rd_ptr_reg];

         always_comb begin
            count_next = count_reg;
            unique case ({enq, deq})
               2'b10:   count_next = count_reg + 1'b1;
               2'b01:   count_next = count_reg - 1'b1;
               default: count_next = count_reg;
            endcase
         end

         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               count_reg  <= '0;
               rd_ptr_reg <= '0;
               wr_ptr_reg <= '0;
            end else begin
               count_reg <= count_next;
               if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
         end

         // Storage needs no reset: v_o masks whatever is left behind.
         always_ff @(posedge clk_i) begin
            if (enq) mem_reg[wr_ptr_reg] <= addr_index;
         end

         a_yumi_needs_valid : assert property (
            @(posedge clk_i) disable iff (reset_i) yumi_i[gi] |-> v_o[gi]
         ) else $error("bank %0d consumed while its FIFO was empty", gi);
      end
   endgenerate

`ifdef BSG_HASH_BANK_DISPATCH_PERF_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_reg <= '0;
      end else if (v_i & ~ready_o & ~(&stall_cnt_reg)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
